// File: rtl/sdram_port_arbiter_if.sv
// Requester-side and SDRAM-controller-side signals of the SDRAM port arbiter.
interface sdram_port_arbiter_if #(
    parameter int NPORTS = 3,
    parameter int AW     = 25,
    parameter int DW     = 16
);
    localparam int IW = $clog2(NPORTS);

    logic [NPORTS-1:0]    req_rd;
    logic [NPORTS-1:0]    req_wr;
    logic [NPORTS*AW-1:0] req_addr;
    logic [NPORTS*DW-1:0] req_wdata;
    logic [NPORTS-1:0]    req_ack;
    logic [DW-1:0]        req_rdata;
    logic                 mem_req;
    logic                 mem_we;
    logic [AW-1:0]        mem_addr;
    logic [DW-1:0]        mem_wdata;
    logic                 mem_ack;
    logic [DW-1:0]        mem_rdata;
    logic [IW-1:0]        grant_idx;
    logic                 busy;

    modport slave (
        input  req_rd, req_wr, req_addr, req_wdata,
        input  mem_ack, mem_rdata,
        output req_ack, req_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata,
        output grant_idx, busy
    );

    modport master (
        output req_rd, req_wr, req_addr, req_wdata,
        output mem_ack, mem_rdata,
        input  req_ack, req_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        input  grant_idx, busy
    );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Multi-port arbiter in front of a single SDRAM controller port.
// Round-robin or fixed priority with a per-port starvation guard.
module sdram_port_arbiter #(
    parameter int NPORTS       = 3,
    parameter int AW           = 25,
    parameter int DW           = 16,
    parameter int MODE         = 0,
    parameter int STARVE_LIMIT = 16
) (
    input logic                 clk,
    input logic                 reset_n,
    sdram_port_arbiter_if.slave bus
);
    localparam int IW = $clog2(NPORTS);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    state_t              state;
    logic [IW-1:0]       rr_ptr;
    logic [IW-1:0]       win;
    logic [IW-1:0]       nxt_ptr;
    logic [7:0]          starve_cnt [NPORTS];
    logic [NPORTS-1:0]   req;
    logic                any_req;
    logic [2*NPORTS-1:0] dbl;
    logic [NPORTS-1:0]   rot;
    int                  off;
    int                  sum;
    logic [AW-1:0]       win_addr;
    logic [DW-1:0]       win_wdata;
    logic                win_wr;

    assign req     = bus.req_rd | bus.req_wr;
    assign any_req = |req;
    assign nxt_ptr = (int'(win) == NPORTS - 1) ? '0 : win + 1'b1;

    // Rotate so the search origin sits at bit 0, then undo the rotation.
    always_comb begin
        dbl = {req, req} >> rr_ptr;
        rot = dbl[NPORTS-1:0];
        off = 0;
        for (int j = NPORTS - 1; j >= 0; j--) begin
            if (rot[j]) off = j;
        end
        sum = int'(rr_ptr) + off;
        if (sum >= NPORTS) sum = sum - NPORTS;
        win = '0;
        if (MODE == 0) begin
            win = IW'(sum);
        end else begin
            for (int i = NPORTS - 1; i >= 0; i--) begin
                if (req[i]) win = IW'(i);
            end
            for (int i = NPORTS - 1; i >= 0; i--) begin
                if (req[i] && starve_cnt[i] >= 8'(STARVE_LIMIT))
                    win = IW'(i);
            end
        end
    end

    always_comb begin
        win_addr  = '0;
        win_wdata = '0;
        win_wr    = 1'b0;
        for (int p = 0; p < NPORTS; p++) begin
            if (int'(win) == p) begin
                win_addr  = bus.req_addr[p*AW +: AW];
                win_wdata = bus.req_wdata[p*DW +: DW];
                win_wr    = bus.req_wr[p];
            end
        end
    end

    // The port currently being served is not considered waiting.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int p = 0; p < NPORTS; p++) starve_cnt[p] <= '0;
        end else begin
            for (int p = 0; p < NPORTS; p++) begin
                if (state == IDLE && any_req && int'(win) == p)
                    starve_cnt[p] <= '0;
                else if (req[p] && starve_cnt[p] != 8'hFF &&
                         !(state != IDLE && int'(bus.grant_idx) == p))
                    starve_cnt[p] <= starve_cnt[p] + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.req_ack   <= '0;
            bus.req_rdata <= '0;
            bus.grant_idx <= '0;
            bus.busy      <= 1'b0;
        end else begin
            bus.req_ack <= '0;
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        state         <= ISSUE;
                        bus.grant_idx <= win;
                        bus.mem_addr  <= win_addr;
                        bus.mem_wdata <= win_wdata;
                        bus.mem_we    <= win_wr;
                        bus.mem_req   <= 1'b1;
                        bus.busy      <= 1'b1;
                        rr_ptr        <= nxt_ptr;
                    end
                end
                ISSUE: state <= WAIT;
                WAIT: begin
                    if (bus.mem_ack) begin
                        state       <= DONE;
                        bus.mem_req <= 1'b0;
                        for (int p = 0; p < NPORTS; p++)
                            bus.req_ack[p] <= (int'(bus.grant_idx) == p);
                        if (!bus.mem_we) bus.req_rdata <= bus.mem_rdata;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/sdram_port_arbiter.md
SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

Interface
REQ-001 Parameter NPORTS, default 3, number of requester ports; legal range 2..8.
REQ-002 Parameter AW, default 25, address width.
REQ-003 Parameter DW, default 16, data width.
REQ-004 Parameter MODE, default 0, arbitration policy: 0 = round-robin, 1 = fixed priority (port 0 highest) with starvation guard.
REQ-005 Parameter STARVE_LIMIT, default 16, wait-cycle threshold for the MODE 1 starvation guard; legal range 1..255.
REQ-006 clk  input  1  single system clock; all logic on rising edge.
REQ-007 reset_n  input  1  asynchronous active-low reset.
REQ-008 req_rd  input  NPORTS  per-port read request, level, held until that port's req_ack.
REQ-009 req_wr  input  NPORTS  per-port write request, level, held until that port's req_ack.
REQ-010 req_addr  input  NPORTS*AW  per-port address; port p occupies bits [p*AW +: AW].
REQ-011 req_wdata  input  NPORTS*DW  per-port write data; port p occupies bits [p*DW +: DW].
REQ-012 req_ack  output  NPORTS  one-cycle completion pulse per port.
REQ-013 req_rdata  output  DW  read data shared by all ports, valid in the req_ack cycle.
REQ-014 mem_req  output  1  request to SDRAM controller, held until mem_ack.
REQ-015 mem_we  output  1  1 = write, 0 = read; valid while mem_req is high.
REQ-016 mem_addr  output  AW  address; valid while mem_req is high.
REQ-017 mem_wdata  output  DW  write data; valid while mem_req is high.
REQ-018 mem_ack  input  1  one-cycle completion from the controller; carries read data.
REQ-019 mem_rdata  input  DW  read data, valid with mem_ack.
REQ-020 grant_idx  output  clog2(NPORTS)  index of the current or last granted port.
REQ-021 busy  output  1  high in every state except IDLE.

Function
REQ-022 FSM states: IDLE, ISSUE, WAIT, DONE. Transitions: IDLE->ISSUE when any port requests; ISSUE->WAIT unconditionally; WAIT->DONE on mem_ack; DONE->IDLE unconditionally.
REQ-023 Arbitration is evaluated only in IDLE. The winner, its address, data and direction are registered on the IDLE->ISSUE edge.
REQ-024 MODE 0: search starts at pointer rr_ptr, ascending with wrap modulo NPORTS. After a grant to port g, rr_ptr = (g+1) mod NPORTS.
REQ-025 MODE 1: the lowest-index requester wins, unless the starvation guard in REQ-026 applies.
REQ-026 MODE 1 starvation guard: each port has an 8-bit saturating counter. The counter increments each cycle the port requests and is not granted, and clears on that port's grant. If any counter is >= STARVE_LIMIT, the lowest-index such port wins.
REQ-027 mem_req is high in ISSUE and WAIT only. mem_addr, mem_wdata and mem_we stay stable from ISSUE until mem_ack.
REQ-028 If req_rd and req_wr are both high on the winning port, the access is a write.
REQ-029 On mem_ack in WAIT, mem_rdata is registered into req_rdata. req_ack[grant_idx] pulses in DONE, exactly one cycle.
REQ-030 Latency: a request sampled in IDLE at cycle N gives mem_req high at N+1. mem_ack at cycle M gives req_ack at M+1. The next arbitration happens at M+2.
REQ-031 A granted transaction always completes, even if the port drops its request before ack; the ack still pulses.
REQ-032 mem_ack received outside WAIT is ignored; state and outputs are unchanged.
REQ-033 mem_ack in the same cycle as entry to WAIT is not possible. mem_ack during ISSUE is ignored.
REQ-034 req_rdata holds its last value between reads. On writes, req_rdata is unchanged.

Reset
REQ-035 While reset_n is low, regardless of clk: state = IDLE; mem_req, mem_we, req_ack and busy = 0; mem_addr, mem_wdata, req_rdata and grant_idx = 0; rr_ptr = 0; starvation counters = 0.
REQ-036 Reset asserted mid-transaction aborts it without an ack. The SDRAM controller shares the same reset.

Verification
REQ-037 NPORTS=3, MODE=0, all three ports request reads continuously, mem_ack 3 cycles after each mem_req -> grants in order 0,1,2,0,1,2; each req_ack is exactly 1 cycle.
REQ-038 Single port 1 write with addr=0x000123, wdata=0xBEEF -> mem_req at N+1 with mem_we=1, mem_addr=0x000123 and mem_wdata=0xBEEF stable until mem_ack; req_ack[1] at mem_ack+1.
REQ-039 MODE=1, STARVE_LIMIT=4, port 0 requests continuously and port 2 requests continuously -> port 2 is granted once its counter reaches 4, then port 0 resumes.
REQ-040 Read on port 0 with mem_rdata=0x5A5A -> req_rdata=0x5A5A in the req_ack[0] cycle. A following write on port 1 leaves req_rdata at 0x5A5A.
REQ-041 reset_n pulsed low during WAIT -> all outputs reach their reset values immediately without waiting for clk; no req_ack is produced; the next request arbitrates from rr_ptr=0.
REQ-042 Spurious mem_ack in IDLE, and port 0 dropping req_rd during WAIT -> the spurious ack is ignored; req_ack[0] still pulses once.
